// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 8x8 unsigned multiplier between NUM_REQ requesters

// multiplier_8bit: combinational 8x8 unsigned multiplier, full 16-bit product
module multiplier_8bit (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);
  assign p_o = a_i * b_i;
endmodule

module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_a_i,
  input  logic [NUM_REQ*8-1:0] req_b_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [15:0]          rsp_data_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o
);
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end
  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("ID_W must equal clog2(NUM_REQ)");
  end

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [15:0]     rsp_data_q;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [15:0]     prod;

  multiplier_8bit u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .p_o (prod)
  );

  // first valid requester strictly after rr_ptr, wrapping around
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid_i[idx]) begin
        gnt_id  = ID_W'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_id : '0;
  assign busy_o      = state_q != IDLE;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

  // accept one request, register the product, hold it until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          a_q      <= req_a_i[int'(gnt_id)*8 +: 8];
          b_q      <= req_b_i[int'(gnt_id)*8 +: 8];
          id_q     <= gnt_id;
          rr_ptr_q <= gnt_id;
          state_q  <= CALC;
        end
        CALC: begin
          rsp_data_q  <= prod;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready_i) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed scenario tests for the shared-multiplier arbiter
module tb_mul_share_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_a = '0;
  logic [N*8-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [15:0]    rsp_data;
  logic           rsp_ready = 1'b0;
  logic           busy;
  int             n_checks = 0;
  int             n_fail = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data),
    .rsp_ready_i (rsp_ready),
    .busy_o      (busy)
  );

  task automatic nx;
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    nx; #1;
    n_checks++;
    if ({rsp_valid, busy, req_ready, rsp_id, rsp_data} !== 24'd0) begin
      n_fail++;
      $display("FAIL reset: got v=%b busy=%b rdy=%b id=%0d data=%h want all zero", rsp_valid, busy, req_ready, rsp_id, rsp_data);
    end
    nx;
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    nx;
    req_valid = 4'b0001; set_op(0, 8'd13, 8'd11); rsp_ready = 1'b1;
    #1; n_checks++;
    if ({req_ready, busy} !== {4'b0001, 1'b0}) begin
      n_fail++; $display("FAIL single_grant: got rdy=%b busy=%b want 0001/0", req_ready, busy);
    end
    nx; req_valid = '0; #1; n_checks++;
    if ({busy, rsp_valid, req_ready} !== {1'b1, 1'b0, 4'b0000}) begin
      n_fail++; $display("FAIL single_calc: got busy=%b v=%b rdy=%b want 1/0/0000", busy, rsp_valid, req_ready);
    end
    nx; #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data, busy} !== {1'b1, 2'd0, 16'h008F, 1'b1}) begin
      n_fail++; $display("FAIL single_rsp: got v=%b id=%0d data=%h busy=%b want 1/0/008f/1", rsp_valid, rsp_id, rsp_data, busy);
    end
    nx; #1; n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin;
    int ord[5] = '{0, 1, 2, 3, 0};
    nx; rst_n = 1'b0;
    nx; rst_n = 1'b1;
    for (int i = 0; i < N; i++) set_op(i, 8'((i + 1) * 10), 8'd3);
    req_valid = 4'b1111; rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1; n_checks++;
      if ({req_ready, rsp_valid} !== {4'(1 << ord[n]), 1'b0}) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got rdy=%b v=%b want %b/0", n, req_ready, rsp_valid, 4'(1 << ord[n]));
      end
      nx;
      if (n == 4) req_valid = '0;
      #1; n_checks++;
      if ({busy, req_ready} !== {1'b1, 4'b0000}) begin
        n_fail++; $display("FAIL rr_calc[%0d]: got busy=%b rdy=%b want 1/0000", n, busy, req_ready);
      end
      nx; #1; n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(ord[n]), 16'((ord[n] + 1) * 30)}) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d data=%0d want 1/%0d/%0d", n, rsp_valid, rsp_id, rsp_data, ord[n], (ord[n] + 1) * 30);
      end
      nx;
    end
    #1; n_checks++;
    if ({busy, req_ready, rsp_valid} !== 6'd0) begin
      n_fail++; $display("FAIL rr_end: got busy=%b rdy=%b v=%b want 0/0000/0", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_backpressure;
    nx;
    req_valid = 4'b0100; set_op(2, 8'd255, 8'd255); set_op(1, 8'd7, 8'd9); rsp_ready = 1'b0;
    #1; n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL bp_grant: got rdy=%b want 0100", req_ready);
    end
    nx; req_valid = 4'b0010; #1; n_checks++;
    if ({busy, req_ready} !== {1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL bp_calc: got busy=%b rdy=%b want 1/0000", busy, req_ready);
    end
    for (int k = 0; k < 6; k++) begin
      nx;
      if (k == 5) rsp_ready = 1'b1;
      #1; n_checks++;
      if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 2'd2, 16'hFE01, 4'b0000}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h rdy=%b want 1/2/fe01/0000", k, rsp_valid, rsp_id, rsp_data, req_ready);
      end
    end
    nx; #1; n_checks++;
    if ({rsp_valid, busy, req_ready} !== {1'b0, 1'b0, 4'b0010}) begin
      n_fail++; $display("FAIL bp_next_grant: got v=%b busy=%b rdy=%b want 0/0/0010", rsp_valid, busy, req_ready);
    end
    nx; req_valid = '0;
    nx; #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd1, 16'h003F}) begin
      n_fail++; $display("FAIL bp_req1_rsp: got v=%b id=%0d data=%h want 1/1/003f", rsp_valid, rsp_id, rsp_data);
    end
    nx;
  endtask

  task automatic test_operands;
    logic [7:0]  va[3] = '{8'd0, 8'd1, 8'd128};
    logic [7:0]  vb[3] = '{8'd200, 8'd173, 8'd2};
    logic [15:0] vp[3] = '{16'h0000, 16'h00AD, 16'h0100};
    for (int i = 1; i < N; i++) set_op(i, 8'hFF, 8'hFF);
    for (int v = 0; v < 3; v++) begin
      nx;
      req_valid = 4'b0001; set_op(0, va[v], vb[v]); rsp_ready = 1'b1;
      #1; n_checks++;
      if (req_ready !== 4'b0001) begin
        n_fail++; $display("FAIL op_grant[%0d]: got rdy=%b want 0001", v, req_ready);
      end
      nx; req_valid = '0;
      nx; #1; n_checks++;
      if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, vp[v]}) begin
        n_fail++; $display("FAIL op_rsp[%0d]: got v=%b id=%0d data=%h want 1/0/%h", v, rsp_valid, rsp_id, rsp_data, vp[v]);
      end
      nx;
    end
  endtask

  task automatic test_reset_mid;
    nx;
    req_valid = 4'b0010; set_op(1, 8'd5, 8'd5); rsp_ready = 1'b1;
    #1; n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rm_grant1: got rdy=%b want 0010", req_ready);
    end
    nx; req_valid = '0;
    #1; rst_n = 1'b0;
    #1; n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rm_calc_abort: got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    nx; rst_n = 1'b1;
    nx;
    req_valid = 4'b0100; set_op(2, 8'd9, 8'd9);
    #1; n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL rm_grant2: got rdy=%b want 0100", req_ready);
    end
    nx; req_valid = '0;
    nx; #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd2, 16'h0051}) begin
      n_fail++; $display("FAIL rm_rsp_before: got v=%b id=%0d data=%h want 1/2/0051", rsp_valid, rsp_id, rsp_data);
    end
    rst_n = 1'b0;
    #1; n_checks++;
    if ({rsp_valid, busy, rsp_id, rsp_data} !== 20'd0) begin
      n_fail++; $display("FAIL rm_resp_abort: got v=%b busy=%b id=%0d data=%h want 0/0/0/0000", rsp_valid, busy, rsp_id, rsp_data);
    end
    nx; rst_n = 1'b1;
    #1; n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rm_no_rsp: got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    nx;
    req_valid = 4'b1001; set_op(0, 8'd6, 8'd7); set_op(3, 8'd3, 8'd3);
    #1; n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rm_ptr_reset: got rdy=%b want 0001", req_ready);
    end
    nx; req_valid = '0;
    nx; #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'd42}) begin
      n_fail++; $display("FAIL rm_rsp_after: got v=%b id=%0d data=%0d want 1/0/42", rsp_valid, rsp_id, rsp_data);
    end
    nx;
  endtask

  task automatic test_drop_while_busy;
    nx;
    req_valid = 4'b0001; set_op(0, 8'd3, 8'd4); rsp_ready = 1'b1;
    #1; n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL dr_grant0: got rdy=%b want 0001", req_ready);
    end
    nx; req_valid = 4'b0010; set_op(1, 8'd8, 8'd8);
    #1; n_checks++;
    if (req_ready !== 4'b0000) begin
      n_fail++; $display("FAIL dr_busy_grant: got rdy=%b want 0000", req_ready);
    end
    nx; req_valid = '0;
    #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'd12}) begin
      n_fail++; $display("FAIL dr_rsp0: got v=%b id=%0d data=%0d want 1/0/12", rsp_valid, rsp_id, rsp_data);
    end
    nx; #1; n_checks++;
    if ({req_ready, busy, rsp_valid} !== 6'd0) begin
      n_fail++; $display("FAIL dr_idle: got rdy=%b busy=%b v=%b want 0000/0/0", req_ready, busy, rsp_valid);
    end
    nx; req_valid = 4'b0001; set_op(0, 8'd20, 8'd20);
    #1; n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL dr_regrant0: got rdy=%b want 0001", req_ready);
    end
    nx; req_valid = '0;
    nx; #1; n_checks++;
    if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'd0, 16'd400}) begin
      n_fail++; $display("FAIL dr_rsp0b: got v=%b id=%0d data=%0d want 1/0/400", rsp_valid, rsp_id, rsp_data);
    end
    nx; nx; req_valid = 4'b0011;
    #1; n_checks++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL dr_ptr: got rdy=%b want 0010", req_ready);
    end
    nx; req_valid = '0;
    nx; nx;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_operands;
    test_reset_mid;
    test_drop_while_busy;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
